// File: rtl/md_sequencer_if.sv
// Multiply/divide unit bus: E-stage issue and operands in, status and HI/LO out.
interface md_sequencer_if;
  localparam int unsigned DW = 32;

  logic          startE;
  logic [2:0]    mult_div_opE;
  logic [DW-1:0] rs_valE;
  logic [DW-1:0] rt_valE;
  logic          m_dD;
  logic          busy;
  logic          stall_md;
  logic [DW-1:0] HI;
  logic [DW-1:0] LO;

  // Pipeline side: issues operations and watches the result registers.
  modport master (
    output startE, mult_div_opE, rs_valE, rt_valE, m_dD,
    input  busy, stall_md, HI, LO
  );

  // Sequencer side.
  modport slave (
    input  startE, mult_div_opE, rs_valE, rt_valE, m_dD,
    output busy, stall_md, HI, LO
  );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide controller: fixed-latency busy window, HI/LO commit at its end.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic           clk,
  input  logic           reset,
  md_sequencer_if.slave  md
);

  localparam int unsigned DW = 32;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [DW-1:0]    hi_q, hi_d;
  logic [DW-1:0]    lo_q, lo_d;
  logic [DW-1:0]    pend_hi_q, pend_hi_d;
  logic [DW-1:0]    pend_lo_q, pend_lo_d;
  logic             pend_we_q, pend_we_d;

  logic             seq_start;
  logic             last_cycle;

  logic signed [2*DW-1:0] a_ext, b_ext, prod_s;
  logic [2*DW-1:0]        prod_u;
  logic                   a_neg, b_neg;
  logic [DW-1:0]          a_mag, b_mag, q_mag, r_mag;
  logic [DW-1:0]          res_hi, res_lo;
  logic                   res_we;

  // Only mult/multu/div/divu (op[2]==0) open a busy window.
  assign seq_start  = md.startE & ~md.mult_div_opE[2];
  assign last_cycle = (cnt_q == CNT_W'(1));

  // Single-cycle arithmetic; the busy window only models the latency.
  always_comb begin
    a_ext  = $signed({{DW{md.rs_valE[DW-1]}}, md.rs_valE});
    b_ext  = $signed({{DW{md.rt_valE[DW-1]}}, md.rt_valE});
    prod_s = a_ext * b_ext;
    prod_u = {{DW{1'b0}}, md.rs_valE} * {{DW{1'b0}}, md.rt_valE};

    // Signed divide via magnitudes: quotient truncates toward zero, remainder follows dividend.
    a_neg  = ~md.mult_div_opE[0] & md.rs_valE[DW-1];
    b_neg  = ~md.mult_div_opE[0] & md.rt_valE[DW-1];
    a_mag  = a_neg ? (~md.rs_valE + DW'(1)) : md.rs_valE;
    b_mag  = b_neg ? (~md.rt_valE + DW'(1)) : md.rt_valE;
    q_mag  = (b_mag == '0) ? '0 : (a_mag / b_mag);
    r_mag  = (b_mag == '0) ? '0 : (a_mag % b_mag);

    res_hi = '0;
    res_lo = '0;
    res_we = 1'b0;
    case (md.mult_div_opE[1:0])
      2'b00: begin
        {res_hi, res_lo} = prod_s;
        res_we           = 1'b1;
      end
      2'b01: begin
        {res_hi, res_lo} = prod_u;
        res_we           = 1'b1;
      end
      default: begin
        res_lo = (a_neg ^ b_neg) ? (~q_mag + DW'(1)) : q_mag;
        res_hi = a_neg ? (~r_mag + DW'(1)) : r_mag;
        res_we = (md.rt_valE != '0);
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (seq_start)  state_d = S_RUN;
      S_RUN:   if (last_cycle) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: operand capture, countdown, commit and mthi/mtlo writes.
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    busy_d    = (state_d == S_RUN);
    case (state_q)
      S_IDLE: begin
        if (seq_start) begin
          cnt_d     = md.mult_div_opE[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_we_d = res_we;
        end else if (md.mult_div_opE == OP_MTHI) begin
          hi_d = md.rs_valE;
        end else if (md.mult_div_opE == OP_MTLO) begin
          lo_d = md.rs_valE;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (last_cycle && pend_we_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  assign md.busy     = busy_q;
  assign md.HI       = hi_q;
  assign md.LO       = lo_q;
  // Combinational so D is held already in the issue cycle, before busy rises.
  assign md.stall_md = md.m_dD & (md.startE | busy_q);

endmodule
